// File: rtl/sc_microseq_pkg.sv
// Shared definitions for the sc_microsequencer slice: microword field
// positions, COND encodings, flag positions, FSM state encoding and the
// opcode-decode address helper.
package sc_microseq_pkg;

  localparam int ADDR_W   = 11;
  localparam int IR_W     = 32;

  // Microword field bit positions
  localparam int RD_BIT   = 19;
  localparam int WR_BIT   = 18;
  localparam int COND_HI  = 13;
  localparam int COND_LO  = 11;
  localparam int JADDR_HI = 10;
  localparam int JADDR_LO = 0;

  // Flag positions inside the {N,Z,V,C} bus
  localparam int FLAG_N   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_V   = 1;
  localparam int FLAG_C   = 0;

  // IR bit tested by COND_IR13
  localparam int IR_TEST_BIT = 13;

  // COND encodings
  localparam logic [2:0] COND_NEXT   = 3'b000;
  localparam logic [2:0] COND_N      = 3'b001;
  localparam logic [2:0] COND_Z      = 3'b010;
  localparam logic [2:0] COND_V      = 3'b011;
  localparam logic [2:0] COND_C      = 3'b100;
  localparam logic [2:0] COND_IR13   = 3'b101;
  localparam logic [2:0] COND_JUMP   = 3'b110;
  localparam logic [2:0] COND_DECODE = 3'b111;

  // FSM state encoding
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // Opcode dispatch target: {1, op, op3, 00} places each op/op3 routine on a
  // 4-word boundary in the upper half of the control store.
  function automatic logic [ADDR_W-1:0] decode_addr(input logic [IR_W-1:0] ir);
    return {1'b1, ir[31:30], ir[24:19], 2'b00};
  endfunction

endpackage

// File: rtl/sc_microseq_next_addr.sv
// Purely combinational next-microaddress selector: sequential increment,
// flag/IR-conditional branches, unconditional jump and opcode decode.
module sc_microseq_next_addr
  import sc_microseq_pkg::*;
(
  input  logic [ADDR_W-1:0] csar_i,
  input  logic [2:0]        cond_i,
  input  logic [ADDR_W-1:0] jaddr_i,
  input  logic [3:0]        flags_i,
  input  logic [IR_W-1:0]   ir_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] seq_addr_s;
  logic [ADDR_W-1:0] dec_addr_s;
  logic              unused_ir_s;

  // Increment wraps modulo 2^11, so 2047 rolls over to 0.
  assign seq_addr_s  = csar_i + 11'd1;
  assign dec_addr_s  = decode_addr(ir_i);
  assign unused_ir_s = ^{ir_i[29:25], ir_i[18:14], ir_i[12:0]};

  // Select the next microaddress according to the COND field.
  always_comb begin
    next_addr_o = seq_addr_s;
    case (cond_i)
      COND_NEXT:   next_addr_o = seq_addr_s;
      COND_N:      next_addr_o = flags_i[FLAG_N]    ? jaddr_i : seq_addr_s;
      COND_Z:      next_addr_o = flags_i[FLAG_Z]    ? jaddr_i : seq_addr_s;
      COND_V:      next_addr_o = flags_i[FLAG_V]    ? jaddr_i : seq_addr_s;
      COND_C:      next_addr_o = flags_i[FLAG_C]    ? jaddr_i : seq_addr_s;
      COND_IR13:   next_addr_o = ir_i[IR_TEST_BIT]  ? jaddr_i : seq_addr_s;
      COND_JUMP:   next_addr_o = jaddr_i;
      COND_DECODE: next_addr_o = dec_addr_s;
      default:     next_addr_o = seq_addr_s;
    endcase
  end

endmodule

// File: rtl/sc_microsequencer.sv
// Microsequencer top: owns the control-store address register (CSAR), a
// two-state RUN / MEM_WAIT FSM that stalls on RD/WR microwords until the
// memory acknowledges, and the commit strobe gating datapath writes.
// Optional build macro CC_MICROSEQUENCER_PERFCNT_EN adds saturating
// commit and memory-wait cycle counters.
module sc_microsequencer
  import sc_microseq_pkg::*;
#(
  parameter int DATAWIDTH_MICROWORD = 41,
  parameter int DATAWIDTH_ADDRESS   = 11,
  parameter int DATAWIDTH_IR        = 32
) (
  input  logic                           CC_MICROSEQUENCER_CLOCK_50,
  input  logic                           CC_MICROSEQUENCER_RESET_InHigh,
  input  logic [DATAWIDTH_MICROWORD-1:0] CC_MICROSEQUENCER_microword_InBUS,
  input  logic [DATAWIDTH_IR-1:0]        CC_MICROSEQUENCER_ir_InBUS,
  input  logic [3:0]                     CC_MICROSEQUENCER_flags_InBUS,
  input  logic                           CC_MICROSEQUENCER_memAck_In,
  output logic [DATAWIDTH_ADDRESS-1:0]   CC_MICROSEQUENCER_address_OutBUS,
  output logic                           CC_MICROSEQUENCER_commit_Out,
  output logic                           CC_MICROSEQUENCER_memReq_Out,
  output logic                           CC_MICROSEQUENCER_memWe_Out
`ifdef CC_MICROSEQUENCER_PERFCNT_EN
  ,
  output logic [31:0]                    CC_MICROSEQUENCER_commitCount_OutBUS,
  output logic [31:0]                    CC_MICROSEQUENCER_waitCount_OutBUS
`endif
);

  logic                         clk;
  logic                         rst;
  logic [DATAWIDTH_MICROWORD-1:0] mw_s;

  logic [0:0]                   state_q, state_d;
  logic [DATAWIDTH_ADDRESS-1:0] csar_q, csar_d;
  logic [DATAWIDTH_ADDRESS-1:0] next_addr_s;

  logic                         rd_s, wr_s, mem_op_s;
  logic                         commit_raw_s, commit_s;
  logic                         mem_req_s, mem_we_s;
  logic                         unused_mw_s;

  assign clk         = CC_MICROSEQUENCER_CLOCK_50;
  assign rst         = CC_MICROSEQUENCER_RESET_InHigh;
  assign mw_s        = CC_MICROSEQUENCER_microword_InBUS;

  assign rd_s        = mw_s[RD_BIT];
  assign wr_s        = mw_s[WR_BIT];
  assign mem_op_s    = rd_s | wr_s;
  // Datapath fields are consumed elsewhere; only sequencing fields are used here.
  assign unused_mw_s = ^{mw_s[40:20], mw_s[17:14]};

  sc_microseq_next_addr u_next_addr (
    .csar_i      (csar_q),
    .cond_i      (mw_s[COND_HI:COND_LO]),
    .jaddr_i     (mw_s[JADDR_HI:JADDR_LO]),
    .flags_i     (CC_MICROSEQUENCER_flags_InBUS),
    .ir_i        (CC_MICROSEQUENCER_ir_InBUS),
    .next_addr_o (next_addr_s)
  );

  // FSM next-state, CSAR update and handshake decode from state plus current word.
  always_comb begin
    state_d      = state_q;
    csar_d       = csar_q;
    commit_raw_s = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    case (state_q)
      ST_RUN: begin
        // memAck is deliberately not looked at in RUN.
        if (mem_op_s) begin
          state_d = ST_MEM_WAIT;
        end else begin
          commit_raw_s = 1'b1;
          csar_d       = next_addr_s;
        end
      end
      ST_MEM_WAIT: begin
        mem_req_s = 1'b1;
        // RD and WR together resolve to a write.
        mem_we_s  = wr_s;
        if (CC_MICROSEQUENCER_memAck_In) begin
          commit_raw_s = 1'b1;
          csar_d       = next_addr_s;
          state_d      = ST_RUN;
        end else begin
          state_d = ST_MEM_WAIT;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // No datapath write may slip through while reset is held.
  assign commit_s = commit_raw_s & ~rst;

  // State and CSAR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      csar_q  <= {DATAWIDTH_ADDRESS{1'b0}};
    end else begin
      state_q <= state_d;
      csar_q  <= csar_d;
    end
  end

  assign CC_MICROSEQUENCER_address_OutBUS = csar_q;
  assign CC_MICROSEQUENCER_commit_Out     = commit_s;
  assign CC_MICROSEQUENCER_memReq_Out     = mem_req_s;
  assign CC_MICROSEQUENCER_memWe_Out      = mem_we_s;

`ifdef CC_MICROSEQUENCER_PERFCNT_EN
  logic [31:0] commit_cnt_q;
  logic [31:0] wait_cnt_q;

  // Saturating counters of commits and of un-acknowledged MEM_WAIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt_q <= 32'd0;
      wait_cnt_q   <= 32'd0;
    end else begin
      if (commit_s && (commit_cnt_q != 32'hFFFF_FFFF)) begin
        commit_cnt_q <= commit_cnt_q + 32'd1;
      end else begin
        commit_cnt_q <= commit_cnt_q;
      end
      if ((state_q == ST_MEM_WAIT) && !CC_MICROSEQUENCER_memAck_In &&
          (wait_cnt_q != 32'hFFFF_FFFF)) begin
        wait_cnt_q <= wait_cnt_q + 32'd1;
      end else begin
        wait_cnt_q <= wait_cnt_q;
      end
    end
  end

  assign CC_MICROSEQUENCER_commitCount_OutBUS = commit_cnt_q;
  assign CC_MICROSEQUENCER_waitCount_OutBUS   = wait_cnt_q;
`endif

endmodule

// File: tb/tb_sc_microsequencer.sv
// Self-checking bench for sc_microsequencer: a vector table of single-cycle
// branch cases plus hand-written memory-handshake and reset sequences.
// Expected outputs are queued when stimulus is driven and compared on the
// falling edge.
module tb_sc_microsequencer;

  logic        clk;
  logic        rst;
  logic [40:0] mw;
  logic [31:0] ir;
  logic [3:0]  flags;
  logic        ack;
  logic [10:0] addr;
  logic        commit, req, we;
`ifdef CC_MICROSEQUENCER_PERFCNT_EN
  logic [31:0] commit_cnt, wait_cnt;
`endif

  int checks;
  int failures;
  int step_id;

  typedef struct {
    int          id;
    logic [2:0]  exp_cre;   // {commit, memReq, memWe}
    logic [2:0]  mask;      // which of the above are checked
    logic [10:0] exp_addr;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [2:0]  cond;
    logic [10:0] jaddr;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic [10:0] addr;
  } vec_t;

  vec_t vecs[18];

  sc_microsequencer dut (
    .CC_MICROSEQUENCER_CLOCK_50        (clk),
    .CC_MICROSEQUENCER_RESET_InHigh    (rst),
    .CC_MICROSEQUENCER_microword_InBUS (mw),
    .CC_MICROSEQUENCER_ir_InBUS        (ir),
    .CC_MICROSEQUENCER_flags_InBUS     (flags),
    .CC_MICROSEQUENCER_memAck_In       (ack),
    .CC_MICROSEQUENCER_address_OutBUS  (addr),
    .CC_MICROSEQUENCER_commit_Out      (commit),
    .CC_MICROSEQUENCER_memReq_Out      (req),
    .CC_MICROSEQUENCER_memWe_Out       (we)
`ifdef CC_MICROSEQUENCER_PERFCNT_EN
    ,
    .CC_MICROSEQUENCER_commitCount_OutBUS (commit_cnt),
    .CC_MICROSEQUENCER_waitCount_OutBUS   (wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [40:0] mkw(input logic rd_b, input logic wr_b,
                                      input logic [2:0] cond, input logic [10:0] jaddr);
    logic [40:0] w;
    w        = 41'd0;
    w[40:35] = 6'h2A;
    w[27]    = 1'b1;
    w[17:14] = 4'h5;
    w[19]    = rd_b;
    w[18]    = wr_b;
    w[13:11] = cond;
    w[10:0]  = jaddr;
    return w;
  endfunction

  task automatic cmp(input string what, input int id, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL step%0d.%s got=%0d exp=%0d", id, what, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show this cycle.
  task automatic step(input logic r, input logic [40:0] w, input logic [31:0] i,
                      input logic [3:0] f, input logic a, input logic [2:0] exp_cre,
                      input logic [2:0] mask, input logic [10:0] exp_addr);
    exp_t e;
    rst   = r;
    mw    = w;
    ir    = i;
    flags = f;
    ack   = a;
    e.id       = step_id;
    e.exp_cre  = exp_cre;
    e.mask     = mask;
    e.exp_addr = exp_addr;
    step_id++;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare combinational outputs and CSAR away from the clock edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.mask[2]) cmp("commit", e.id, {31'd0, commit}, {31'd0, e.exp_cre[2]});
      if (e.mask[1]) cmp("memReq", e.id, {31'd0, req},    {31'd0, e.exp_cre[1]});
      if (e.mask[0]) cmp("memWe",  e.id, {31'd0, we},     {31'd0, e.exp_cre[0]});
      cmp("csar", e.id, {21'd0, addr}, {21'd0, e.exp_addr});
    end
  end

  initial begin
    logic [40:0] nop, w;
    checks   = 0;
    failures = 0;
    step_id  = 0;
    nop      = mkw(1'b0, 1'b0, 3'b000, 11'd9);

    vecs[0]  = '{3'b110, 11'd1600, 32'h0000_0000, 4'b0000, 11'd1};
    vecs[1]  = '{3'b101, 11'd1602, 32'h0000_2000, 4'b0000, 11'd1600};
    vecs[2]  = '{3'b110, 11'd1600, 32'h0000_0000, 4'b0000, 11'd1602};
    vecs[3]  = '{3'b101, 11'd1602, 32'hFFFF_DFFF, 4'b1111, 11'd1600};
    vecs[4]  = '{3'b111, 11'd5,    32'hC000_0000, 4'b0000, 11'd1601};
    vecs[5]  = '{3'b111, 11'd5,    32'hBE87_FFFF, 4'b1111, 11'd1792};
    vecs[6]  = '{3'b001, 11'd100,  32'h0000_0000, 4'b1000, 11'd1600};
    vecs[7]  = '{3'b001, 11'd5,    32'h0000_0000, 4'b0111, 11'd100};
    vecs[8]  = '{3'b010, 11'd200,  32'h0000_0000, 4'b0100, 11'd101};
    vecs[9]  = '{3'b010, 11'd5,    32'h0000_0000, 4'b1011, 11'd200};
    vecs[10] = '{3'b011, 11'd300,  32'h0000_0000, 4'b0010, 11'd201};
    vecs[11] = '{3'b011, 11'd5,    32'h0000_0000, 4'b1101, 11'd300};
    vecs[12] = '{3'b100, 11'd400,  32'h0000_0000, 4'b0001, 11'd301};
    vecs[13] = '{3'b100, 11'd5,    32'h0000_0000, 4'b1110, 11'd400};
    vecs[14] = '{3'b000, 11'd7,    32'hFFFF_FFFF, 4'b1111, 11'd401};
    vecs[15] = '{3'b110, 11'd2047, 32'h0000_0000, 4'b0000, 11'd402};
    vecs[16] = '{3'b000, 11'd5,    32'h0000_0000, 4'b0000, 11'd2047};
    vecs[17] = '{3'b000, 11'd5,    32'h0000_0000, 4'b0000, 11'd0};

    rst = 1'b1; mw = nop; ir = 32'd0; flags = 4'd0; ack = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // Reset held: CSAR 0, no commit, no request
    step(1'b1, nop, 32'd0, 4'd0, 1'b0, 3'b000, 3'b111, 11'd0);

    // Read at word 0, ack in the third MEM_WAIT cycle; ack in RUN ignored
    w = mkw(1'b1, 1'b0, 3'b000, 11'd9);
    step(1'b0, w, 32'd0, 4'd0, 1'b1, 3'b000, 3'b111, 11'd0);
    step(1'b0, w, 32'd0, 4'd0, 1'b0, 3'b010, 3'b111, 11'd0);
    step(1'b0, w, 32'd0, 4'd0, 1'b0, 3'b010, 3'b111, 11'd0);
    step(1'b0, w, 32'd0, 4'd0, 1'b1, 3'b110, 3'b111, 11'd0);

    // Single-cycle branch table, starting at CSAR 1
    for (int k = 0; k < 18; k++) begin
      step(1'b0, mkw(1'b0, 1'b0, vecs[k].cond, vecs[k].jaddr), vecs[k].ir,
           vecs[k].flags, 1'b0, 3'b100, 3'b111, vecs[k].addr);
    end

    // RD=WR=1 resolves to a write, then jumps to 50
    w = mkw(1'b1, 1'b1, 3'b110, 11'd50);
    step(1'b0, w, 32'd0, 4'd0, 1'b1, 3'b000, 3'b111, 11'd1);
    step(1'b0, w, 32'd0, 4'd0, 1'b0, 3'b011, 3'b111, 11'd1);
    step(1'b0, w, 32'd0, 4'd0, 1'b1, 3'b111, 3'b111, 11'd1);

    // Minimum-latency write: ack in the first MEM_WAIT cycle
    w = mkw(1'b0, 1'b1, 3'b000, 11'd9);
    step(1'b0, w, 32'd0, 4'd0, 1'b0, 3'b000, 3'b111, 11'd50);
    step(1'b0, w, 32'd0, 4'd0, 1'b1, 3'b111, 3'b111, 11'd50);

    // Flags only matter in the commit cycle: Z set in RUN, clear at ack
    w = mkw(1'b1, 1'b0, 3'b010, 11'd700);
    step(1'b0, w, 32'd0, 4'b0100, 1'b0, 3'b000, 3'b111, 11'd51);
    step(1'b0, w, 32'd0, 4'b0000, 1'b1, 3'b110, 3'b111, 11'd51);

    // Reset while in MEM_WAIT, with an ack that must not commit
    w = mkw(1'b1, 1'b0, 3'b000, 11'd9);
    step(1'b0, w, 32'd0, 4'd0, 1'b0, 3'b000, 3'b111, 11'd52);
    step(1'b0, w, 32'd0, 4'd0, 1'b0, 3'b010, 3'b111, 11'd52);
    step(1'b1, w, 32'd0, 4'd0, 1'b1, 3'b000, 3'b101, 11'd52);
    step(1'b1, nop, 32'd0, 4'd0, 1'b0, 3'b000, 3'b111, 11'd0);

    // Five commits and three wait cycles after reset
    step(1'b0, nop, 32'd0, 4'd0, 1'b0, 3'b100, 3'b111, 11'd0);
    step(1'b0, w,   32'd0, 4'd0, 1'b0, 3'b000, 3'b111, 11'd1);
    step(1'b0, w,   32'd0, 4'd0, 1'b0, 3'b010, 3'b111, 11'd1);
    step(1'b0, w,   32'd0, 4'd0, 1'b0, 3'b010, 3'b111, 11'd1);
    step(1'b0, w,   32'd0, 4'd0, 1'b0, 3'b010, 3'b111, 11'd1);
    step(1'b0, w,   32'd0, 4'd0, 1'b1, 3'b110, 3'b111, 11'd1);
    step(1'b0, nop, 32'd0, 4'd0, 1'b0, 3'b100, 3'b111, 11'd2);
    step(1'b0, nop, 32'd0, 4'd0, 1'b0, 3'b100, 3'b111, 11'd3);
    step(1'b0, nop, 32'd0, 4'd0, 1'b0, 3'b100, 3'b111, 11'd4);

    #1;
    cmp("final_csar", step_id, {21'd0, addr}, 32'd5);
    cmp("sb_drained", step_id, sb.size(), 32'd0);
`ifdef CC_MICROSEQUENCER_PERFCNT_EN
    cmp("commitCount", step_id, commit_cnt, 32'd5);
    cmp("waitCount",   step_id, wait_cnt,   32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_microsequencer.md
# sc_microsequencer

Microsequencer for the 41-bit horizontal control store. It holds the 11-bit control-store address register (CSAR) and computes the next microaddress from the COND/JUMP ADDR fields, the ALU flags and the instruction register. It also runs a req/ack handshake with main memory for microwords carrying RD or WR, and stalls the microprogram until the memory acknowledges. It sits between the control store, the datapath flag register, the IR and the memory interface, and is the only writer of the control-store address.

## Interface
Parameters:
- DATAWIDTH_MICROWORD, 41, control-store word width
- DATAWIDTH_ADDRESS, 11, microaddress width
- DATAWIDTH_IR, 32, instruction register width

Ports:
- CC_MICROSEQUENCER_CLOCK_50  in  1  sole clock, rising edge
- CC_MICROSEQUENCER_RESET_InHigh  in  1  reset, synchronous, active-high
- CC_MICROSEQUENCER_microword_InBUS  in  41  word read from the control store at the current CSAR
- CC_MICROSEQUENCER_ir_InBUS  in  32  current instruction
- CC_MICROSEQUENCER_flags_InBUS  in  4  {N,Z,V,C} from the PSR
- CC_MICROSEQUENCER_memAck_In  in  1  memory done, single-cycle pulse
- CC_MICROSEQUENCER_address_OutBUS  out  11  CSAR, which drives the control-store address
- CC_MICROSEQUENCER_commit_Out  out  1  current microword commits this cycle; gates all datapath register writes
- CC_MICROSEQUENCER_memReq_Out  out  1  memory request
- CC_MICROSEQUENCER_memWe_Out  out  1  1 = write, 0 = read; valid while memReq is high

## Operation
- Microword fields (MSB..LSB):
  - A[40:35], AMUX[34], B[33:28], BMUX[27], C[26:21], CMUX[20]
  - RD[19], WR[18], ALU[17:14]
  - COND[13:11], JADDR[10:0]
- Next address by COND:
  - 000: CSAR+1
  - 001: JADDR if N, else CSAR+1
  - 010: JADDR if Z, else CSAR+1
  - 011: JADDR if V, else CSAR+1
  - 100: JADDR if C, else CSAR+1
  - 101: JADDR if IR[13], else CSAR+1
  - 110: JADDR unconditionally
  - 111: decode = {1'b1, IR[31:30], IR[24:19], 2'b00}. Example: op=10, op3=010000 gives 1600.
- CSAR+1 is 11-bit modulo: 2047+1 wraps to 0.
- FSM states: RUN, MEM_WAIT.
  - RUN, RD=WR=0: commit=1, CSAR <= next; stay in RUN.
  - RUN, RD|WR=1: commit=0; CSAR holds; go to MEM_WAIT.
  - MEM_WAIT: memReq=1 and memWe=WR. On ack: commit=1, CSAR <= next, go to RUN. Without ack: hold.
- RD=WR=1 in the same word is treated as a write (memWe=1).
- memAck in RUN is ignored.
- Flags and IR are sampled in the commit cycle only.
- Reset values: CSAR=0, state=RUN, commit=0, memReq=0, memWe=0.
- Reset in MEM_WAIT drops memReq on the next edge; no commit occurs.

## Timing
- CSAR is registered. The path CSAR -> control store -> next-address logic -> CSAR D is a single-cycle combinational loop through an external ROM.
- commit, memReq and memWe are decoded from state plus the current microword. They are valid in the same cycle and are not registered.
- Non-memory microword: 1 cycle.
- Memory microword: 1 cycle in RUN plus N>=1 cycles in MEM_WAIT. The minimum is 2 cycles, with ack in the first MEM_WAIT cycle.
- First cycle after reset deassertion: address_OutBUS=0; commit is evaluated on word 0.

## Configuration
- CC_MICROSEQUENCER_PERFCNT_EN defined:
  - Adds two 32-bit outputs: CC_MICROSEQUENCER_commitCount_OutBUS and CC_MICROSEQUENCER_waitCount_OutBUS.
  - commitCount increments on every commit; waitCount increments on every MEM_WAIT cycle without ack.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Not defined: the ports and counters are absent. Sequencing behaviour is identical in both builds.

## Structure
- Package sc_microseq_pkg holds:
  - field bit-position localparams (RD_BIT, WR_BIT, COND_HI/LO, JADDR_HI/LO)
  - COND encodings (COND_NEXT, COND_N, COND_Z, COND_V, COND_C, COND_IR13, COND_JUMP, COND_DECODE)
  - state encoding (ST_RUN, ST_MEM_WAIT)
- Sub-module sc_microseq_next_addr: purely combinational. Inputs are CSAR, COND, JADDR, flags and IR; output is the next address. It holds the mux and the decode concatenation.

## Test plan
- Reset, then microword at 0 with RD=1 and COND=000, ack after 3 cycles -> memReq high for 3 cycles, memWe=0; commit in the ack cycle; CSAR goes 0 -> 1.
- CSAR=1600, COND=101, JADDR=1602, IR[13]=1 -> CSAR=1602; repeat with IR[13]=0 -> CSAR=1601.
- COND=111, IR[31:30]=11, IR[24:19]=000000 -> CSAR=1792; IR op=10, op3=010000 -> CSAR=1600.
- COND=110 with JADDR=2047, then COND=000 at 2047 -> CSAR wraps to 0.
- RD=WR=1 -> memWe=1. Reset asserted in MEM_WAIT -> next cycle memReq=0, CSAR=0, and no commit pulse is seen.
- With CC_MICROSEQUENCER_PERFCNT_EN: 5 commits and 3 wait cycles -> commitCount=5, waitCount=3.
